// File: rtl/pixel_sum_pack.sv
// Converts approximate-adder sums {cout,sum} to 8-bit pixels (saturate/average/truncate),
// buffers them in a 2-entry FIFO, tags line/frame ends and counts saturations per frame.
module pixel_sum_pack #(
  parameter int LINE_LEN    = 640,
  parameter int FRAME_LINES = 480,
  parameter int CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_sum,
  input  logic             in_cout,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_pix,
  output logic             out_eol,
  output logic             out_eof,
  output logic [CNT_W-1:0] frame_sat
);

  localparam int XW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int YW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(LINE_LEN - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_LINES - 1);

  typedef struct packed {
    logic [7:0] pix;
    logic       eol;
    logic       eof;
  } entry_t;

  entry_t [1:0]     mem_q;
  logic             rd_q, wr_q;
  logic [1:0]       cnt_q;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic [CNT_W-1:0] frame_sat_q, frame_sat_d;

  logic       push, pop;
  logic [9:0] v, h;
  logic [7:0] conv_pix;
  logic       conv_sat;
  logic       eol_tag, eof_tag;
  logic [CNT_W:0] fs_sum;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_pix   = mem_q[rd_q].pix;
  assign out_eol   = mem_q[rd_q].eol;
  assign out_eof   = mem_q[rd_q].eof;
  assign frame_sat = frame_sat_q;

  assign v = {in_cout, in_sum};
  assign h = {1'b0, v[9:1]};

  always_comb begin
    conv_pix = v[7:0];
    conv_sat = 1'b0;
    case (mode)
      2'b01: begin
        conv_sat = (h[9:8] != 2'b00);
        conv_pix = conv_sat ? 8'hFF : h[7:0];
      end
      2'b10: begin
        conv_sat = 1'b0;
        conv_pix = v[7:0];
      end
      default: begin
        conv_sat = (v[9:8] != 2'b00);
        conv_pix = conv_sat ? 8'hFF : v[7:0];
      end
    endcase
  end

  assign eol_tag = (x_q == X_LAST);
  assign eof_tag = eol_tag && (y_q == Y_LAST);
  assign fs_sum  = {1'b0, sat_cnt_q} + {{CNT_W{1'b0}}, conv_sat};

  // Position and saturation bookkeeping only move on an accepted sum.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    sat_cnt_d   = sat_cnt_q;
    frame_sat_d = frame_sat_q;
    if (push) begin
      if (eol_tag) begin
        x_d = '0;
        y_d = eof_tag ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      if (eof_tag) begin
        frame_sat_d = fs_sum[CNT_W] ? '1 : fs_sum[CNT_W-1:0];
        sat_cnt_d   = '0;
      end else if (conv_sat && (sat_cnt_q != '1)) begin
        sat_cnt_d = sat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= 2'd0;
      x_q         <= '0;
      y_q         <= '0;
      sat_cnt_q   <= '0;
      frame_sat_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= '{pix: conv_pix, eol: eol_tag, eof: eof_tag};
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      x_q         <= x_d;
      y_q         <= y_d;
      sat_cnt_q   <= sat_cnt_d;
      frame_sat_q <= frame_sat_d;
    end
  end

endmodule
